// File: rtl/shift_reg_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer_pkg
//   Shared definitions for the shift-register sequencer and its tick divider.
//   - state_t       : sequencer FSM encoding (IDLE=0 .. DONE=4), 3 bits wide
//   - is_run_state  : 1 for the states in which the tick divider runs
//   - bitcnt_width  : width of the shift counter for an N-stage register
// ---------------------------------------------------------------------------
package shift_reg_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // The divider only produces ticks while the register is loading or shifting.
  function automatic logic is_run_state(input state_t s);
    return (s == ST_LOAD) || (s == ST_SHIFT);
  endfunction

  // One extra bit over clog2(N) so the counter can hold N-1 with headroom.
  function automatic int bitcnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/shift_reg_sequencer_tick.sv
// ---------------------------------------------------------------------------
// shift_tick_divider
//   Programmable tick generator.  Produces a one-cycle tick every
//   (period+1) cycles while running.
//
//   Ports
//     clock   in   1    rising-edge clock
//     reset   in   1    synchronous, active-high reset
//     run     in   1    divider is running in the UPCOMING cycle
//     period  in   PW   tick period minus one, valid for the upcoming cycle
//     tick    out  1    registered tick, high for exactly one cycle per period
//
//   run/period describe the next cycle rather than the current one so that
//   tick can come straight from a flop yet still line up with the cycle in
//   which the owner is in a run state.  The counter restarts from 0 whenever
//   the divider is (re)started and is held at 0 while run is low.
// ---------------------------------------------------------------------------
module shift_tick_divider
  import shift_reg_sequencer_pkg::*;
#(
  parameter int prescaleWidth = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     run,
  input  logic [prescaleWidth-1:0] period,
  output logic                     tick
);

  logic [prescaleWidth-1:0] count_reg;
  logic [prescaleWidth-1:0] count_next;
  logic                     active_reg;
  logic                     tick_reg;

  // Advance only when the divider was already running and did not just wrap.
  // A tick marks count==period, so the increment never passes the maximum.
  always_comb begin
    count_next = '0;
    if (run && active_reg && !tick_reg) begin
      count_next = count_reg + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      active_reg <= run;
      count_reg  <= count_next;
      tick_reg   <= run && (count_next == period);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/shift_reg_sequencer.sv
// ---------------------------------------------------------------------------
// shift_reg_sequencer
//   Drives a single-lane, N-stage shift register: accepts a word over a
//   valid/ready handshake, parallel-loads it on a tick, shifts it N times at
//   a programmable tick rate, then returns the register contents.
//
//   Ports
//     clock, reset      rising-edge clock, synchronous active-high reset
//     start_valid/ready request handshake (ready only in IDLE)
//     load_data [N]     word to parallel-load
//     prescale  [PW]    tick period minus one (latched at acceptance)
//     abort             cancel any in-flight operation, pulse sr_clear
//     busy              high in every state except IDLE
//     done_valid/ready  result handshake
//     result_data [N]   captured register contents
//     sr_parLoad, sr_shiftEnable, sr_tick, sr_d [N], sr_clear
//                       control outputs to the shift register
//     sr_q [N]          shift register contents
//
//   All sr_* outputs and result_data are flops.  They are loaded from the
//   next-state decode so that, cycle by cycle, they agree with the state
//   currently held in state_reg.
// ---------------------------------------------------------------------------
module shift_reg_sequencer
  import shift_reg_sequencer_pkg::*;
#(
  parameter int nrOfStages    = 8,
  parameter int prescaleWidth = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start_valid,
  output logic                     start_ready,
  input  logic [nrOfStages-1:0]    load_data,
  input  logic [prescaleWidth-1:0] prescale,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [nrOfStages-1:0]    result_data,
  output logic                     sr_parLoad,
  output logic                     sr_shiftEnable,
  output logic                     sr_tick,
  output logic [nrOfStages-1:0]    sr_d,
  output logic                     sr_clear,
  input  logic [nrOfStages-1:0]    sr_q
);

  localparam int CNT_W = bitcnt_width(nrOfStages);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(nrOfStages - 1);

  state_t                   state_reg;
  state_t                   state_next;
  logic [prescaleWidth-1:0] p_reg;
  logic [prescaleWidth-1:0] p_next;
  logic [CNT_W-1:0]         bitcnt_reg;
  logic [CNT_W-1:0]         bitcnt_next;

  logic                     parload_reg;
  logic                     shift_en_reg;
  logic                     clear_reg;
  logic [nrOfStages-1:0]    d_reg;
  logic [nrOfStages-1:0]    result_reg;

  logic                     accept;
  logic                     capture;
  logic                     tick;

  // Abort beats a simultaneous request.
  assign accept  = (state_reg == ST_IDLE) && start_valid && !abort;
  // An abort landing in CAPTURE leaves the previous result untouched.
  assign capture = (state_reg == ST_CAPTURE) && !abort;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    bitcnt_next = bitcnt_reg;
    p_next      = p_reg;

    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_valid) begin
            state_next = ST_LOAD;
            p_next     = prescale;
          end
        end
        ST_LOAD: begin
          // The tick that performs the parallel load also ends LOAD.
          if (tick) begin
            state_next  = ST_SHIFT;
            bitcnt_next = '0;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bitcnt_reg == LAST_BIT) begin
              state_next = ST_CAPTURE;
            end else begin
              bitcnt_next = bitcnt_reg + 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          state_next = ST_DONE;
        end
        ST_DONE: begin
          if (done_ready) begin
            state_next = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Tick divider: told about the upcoming state so its registered tick lines
  // up with the LOAD/SHIFT cycles.  Leaving LOAD/SHIFT (including abort)
  // drops run and clears the counter; LOAD->SHIFT happens on a tick, where
  // the counter wraps to 0 anyway.
  // -------------------------------------------------------------------------
  shift_tick_divider #(
    .prescaleWidth(prescaleWidth)
  ) u_divider (
    .clock  (clock),
    .reset  (reset),
    .run    (is_run_state(state_next)),
    .period (p_next),
    .tick   (tick)
  );

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      p_reg        <= '0;
      bitcnt_reg   <= '0;
      parload_reg  <= 1'b0;
      shift_en_reg <= 1'b0;
      clear_reg    <= 1'b1;
      d_reg        <= '0;
      result_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      p_reg        <= p_next;
      bitcnt_reg   <= bitcnt_next;
      parload_reg  <= (state_next == ST_LOAD);
      shift_en_reg <= (state_next == ST_SHIFT);
      clear_reg    <= abort;
      if (accept) begin
        d_reg <= load_data;
      end
      // The last shift edge has already happened when CAPTURE is entered,
      // so sr_q is settled for either clock polarity of the register build.
      if (capture) begin
        result_reg <= sr_q;
      end
    end
  end

  assign start_ready    = (state_reg == ST_IDLE);
  assign busy           = (state_reg != ST_IDLE);
  assign done_valid     = (state_reg == ST_DONE);
  assign result_data    = result_reg;
  assign sr_parLoad     = parload_reg;
  assign sr_shiftEnable = shift_en_reg;
  assign sr_tick        = tick;
  assign sr_d           = d_reg;
  assign sr_clear       = clear_reg;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
`timescale 1ns/1ps
module tb_shift_reg_sequencer;

  localparam int N  = 8;
  localparam int PW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [N-1:0]  load_data;
  logic [PW-1:0] prescale;
  logic          abort;
  logic          busy;
  logic          done_valid;
  logic          done_ready;
  logic [N-1:0]  result_data;
  logic          sr_parLoad;
  logic          sr_shiftEnable;
  logic          sr_tick;
  logic [N-1:0]  sr_d;
  logic          sr_clear;
  logic [N-1:0]  sr_q;
  logic          shift_in;

  always #5 clock = ~clock;

  shift_reg_sequencer #(.nrOfStages(N), .prescaleWidth(PW)) dut (
    .clock          (clock),
    .reset          (reset),
    .start_valid    (start_valid),
    .start_ready    (start_ready),
    .load_data      (load_data),
    .prescale       (prescale),
    .abort          (abort),
    .busy           (busy),
    .done_valid     (done_valid),
    .done_ready     (done_ready),
    .result_data    (result_data),
    .sr_parLoad     (sr_parLoad),
    .sr_shiftEnable (sr_shiftEnable),
    .sr_tick        (sr_tick),
    .sr_d           (sr_d),
    .sr_clear       (sr_clear),
    .sr_q           (sr_q)
  );

  // Edge counter: at a negedge, cyc is the index of the most recent rising edge.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Serial input: mode 0 -> constant 0, 1 -> constant 1, 2 -> random pattern.
  bit pattern [4096];
  int sin_mode = 0;

  function automatic logic sin_at(input int c, input int mode);
    if (mode == 2) return pattern[c % 4096];
    return mode[0];
  endfunction

  always @(negedge clock) shift_in = sin_at(cyc, sin_mode);

  // Closed-loop single-lane shift register (parLoad has priority over shift).
  always @(posedge clock) begin
    if (sr_clear) sr_q <= '0;
    else if (sr_tick) begin
      if (sr_parLoad) sr_q <= sr_d;
      else if (sr_shiftEnable) sr_q <= {sr_q[N-2:0], shift_in};
    end
  end

  // Reference: the k-th shift (k=1..N) happens on edge e0+(P+1)(k+1) and
  // takes the serial bit driven before that edge; it ends at bit N-k.
  function automatic logic [N-1:0] model_result(input int e0, input int p, input int mode);
    logic [N-1:0] r;
    r = '0;
    for (int k = 1; k <= N; k++) r[N-k] = sin_at(e0 + (p + 1) * (k + 1) - 1, mode);
    return r;
  endfunction

  typedef struct {
    logic [N-1:0] result;
    int           e0;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expectations shared with the monitor for the operation in flight.
  logic [N-1:0] exp_d = '0;
  int           exp_p = 0;
  logic [N-1:0] last_result = '0;

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic         done_prev = 1'b0;
  logic [N-1:0] held = '0;
  int           tick_cnt = 0;
  int           last_tick = 0;
  exp_t         mon_e;

  always @(negedge clock) begin
    if (done_valid === 1'b1 && !done_prev) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("result", 32'(result_data), 32'(mon_e.result));
        check("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
        check("tick_count", 32'(tick_cnt), 32'(N + 1));
        $display("done: result=%02h latency=%0d ticks=%0d", result_data, cyc - mon_e.e0, tick_cnt);
      end
      held = result_data;
    end else if (done_valid === 1'b1) begin
      check("done_hold", 32'(result_data), 32'(held));
    end
    done_prev = (done_valid === 1'b1);

    if (sr_tick === 1'b1) begin
      check("tick_in_run", 32'(sr_parLoad ^ sr_shiftEnable), 32'd1);
      if (sr_parLoad) check("sr_d", 32'(sr_d), 32'(exp_d));
    end

    if (busy !== 1'b1) tick_cnt = 0;
    else if (sr_tick === 1'b1) begin
      if (tick_cnt > 0) check("tick_gap", 32'(cyc - last_tick), 32'(exp_p + 1));
      tick_cnt++;
      last_tick = cyc;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic [N-1:0] data, input int p, input int mode,
                       input int abort_at, input int hold);
    int lat;
    int j;
    lat = (N + 1) * (p + 1) + 1;
    j = 0;
    while (!start_ready && j < 50) begin
      @(negedge clock);
      j++;
    end
    check("idle_before_req", 32'(start_ready), 32'd1);
    sin_mode    = mode;
    start_valid = 1'b1;
    load_data   = data;
    prescale    = PW'(p);
    exp_d       = data;
    exp_p       = p;
    if (abort_at == 0) sb.push_back('{model_result(cyc + 1, p, mode), cyc + 1, lat});
    $display("req: data=%02h P=%0d mode=%0d abort_at=%0d hold=%0d", data, p, mode, abort_at, hold);
    @(negedge clock);
    start_valid = 1'b0;
    load_data   = N'($urandom);
    prescale    = PW'($urandom);
    check("accepted_busy", 32'(busy), 32'd1);
    if (abort_at > 0) begin
      for (int k = 1; k < abort_at; k++) @(negedge clock);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ready", 32'(start_ready), 32'd1);
      check("abort_clear", 32'(sr_clear), 32'd1);
      check("abort_result", 32'(result_data), 32'(last_result));
      @(negedge clock);
      check("abort_clear_pulse", 32'(sr_clear), 32'd0);
      check("abort_sr_q", 32'(sr_q), 32'd0);
      check("abort_no_done", 32'(done_valid), 32'd0);
    end else begin
      j = 1;
      while (!done_valid && j < lat + 4) begin
        @(negedge clock);
        j++;
      end
      check("done_seen", 32'(done_valid), 32'd1);
      for (int h = 0; h < hold; h++) begin
        start_valid = 1'($urandom_range(0, 1));
        load_data   = N'($urandom);
        check("done_not_ready", 32'(start_ready), 32'd0);
        check("done_sr_d", 32'(sr_d), 32'(data));
        @(negedge clock);
      end
      start_valid = (hold > 0);
      done_ready  = 1'b1;
      @(negedge clock);
      done_ready  = 1'b0;
      start_valid = 1'b0;
      check("release_idle", 32'(start_ready), 32'd1);
      check("release_busy", 32'(busy), 32'd0);
      last_result = held;
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) pattern[i] = 1'($urandom_range(0, 1));
    reset = 1'b1; start_valid = 1'b0; load_data = '0; prescale = '0;
    abort = 1'b0; done_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_clear", 32'(sr_clear), 32'd1);
    check("reset_ready", 32'(start_ready), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    check("post_reset_clear", 32'(sr_clear), 32'd0);
    check("post_reset_busy", 32'(busy), 32'd0);
    check("post_reset_done", 32'(done_valid), 32'd0);
    check("post_reset_result", 32'(result_data), 32'd0);
    check("post_reset_ctrl", 32'({sr_parLoad, sr_shiftEnable, sr_tick}), 32'd0);
    check("post_reset_sr_d", 32'(sr_d), 32'd0);
    check("post_reset_sr_q", 32'(sr_q), 32'd0);

    // Directed: fast shift of 0s, slow shift of 1s, abort in SHIFT, long DONE hold.
    do_op(8'hA5, 0, 0, 0, 0);
    do_op(8'h81, 3, 1, 0, 0);
    do_op(8'h3C, 1, 2, 5, 0);
    do_op(8'h5A, 0, 2, 0, 20);

    // start_valid together with abort in IDLE: not accepted.
    start_valid = 1'b1; abort = 1'b1; load_data = ~exp_d; prescale = '0;
    @(negedge clock);
    start_valid = 1'b0; abort = 1'b0;
    check("idle_abort_busy", 32'(busy), 32'd0);
    check("idle_abort_clear", 32'(sr_clear), 32'd1);
    check("idle_abort_sr_d", 32'(sr_d), 32'(exp_d));
    @(negedge clock);
    check("idle_abort_stays", 32'({busy, sr_parLoad}), 32'd0);
    $display("idle abort: busy=%0b sr_d=%02h", busy, sr_d);

    // Synchronous reset in the middle of SHIFT.
    sin_mode = 2; start_valid = 1'b1; load_data = 8'hC3; prescale = 4'd1;
    exp_d = 8'hC3; exp_p = 1;
    @(negedge clock);
    start_valid = 1'b0;
    for (int k = 0; k < 20 && !sr_shiftEnable; k++) @(negedge clock);
    check("reached_shift", 32'(sr_shiftEnable), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset_ready", 32'(start_ready), 32'd1);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_done", 32'(done_valid), 32'd0);
    check("midreset_result", 32'(result_data), 32'd0);
    check("midreset_ctrl", 32'({sr_parLoad, sr_shiftEnable, sr_tick}), 32'd0);
    check("midreset_sr_d", 32'(sr_d), 32'd0);
    check("midreset_clear", 32'(sr_clear), 32'd1);
    @(negedge clock);
    check("midreset_clear_end", 32'(sr_clear), 32'd0);
    $display("mid-shift reset: busy=%0b result=%02h", busy, result_data);
    last_result = '0;
    exp_d = '0;

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      int p;
      int lat;
      int ab;
      p   = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
      lat = (N + 1) * (p + 1) + 1;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat) : 0;
      do_op(N'($urandom), p, $urandom_range(0, 2), ab, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clock);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", compared, mismatched);
    $fatal(1, "watchdog");
  end

endmodule
